bist_engine_param: RTL and testbench
====================================

# bist_engine_param

Parametrised successor to the fixed-width BIST block. It generates LFSR test patterns for the logic under test, drives the logic's reset and clock strobes, and compacts the logic's responses into a MISR signature. At the end of the run it compares the signature against a golden value. It sits between the TAP-side BIST data register (start, golden, results) and the BIST/BSC mux/demux in front of the logic under test.

## Interface
- X_WIDTH, 4: pattern width driven to the logic (1..16).
- Y_WIDTH, 4: response width from the logic (1..SIG_WIDTH).
- SIG_WIDTH, 16: MISR/signature width (2..32).
- PAT_COUNT, 15: patterns per run (1..65535).
- RST_CYCLES, 2: cycles logic reset is held before the first pattern (≥1).
- LFSR_POLY, 4'b1100: Fibonacci tap mask, X_WIDTH bits.
- LFSR_SEED, 4'b0001: LFSR load value. A value of 0 is replaced by 1.
- MISR_POLY, 16'h8016: MISR feedback tap mask, SIG_WIDTH bits.

Ports:
- clk_50MHz, in, 1: single clock; all state changes on its rising edge.
- BIST_res_n, in, 1: asynchronous, active-low reset.
- start, in, 1: run request; rising edge sensed.
- abort, in, 1: level; cancels the run.
- golden, in, SIG_WIDTH: expected signature.
- BIST_to_logic_X, out, X_WIDTH: pattern.
- BIST_to_logic_clk, out, 1: one-cycle strobe; the logic samples X on it.
- BIST_to_logic_res, out, 1: active-high reset to the logic.
- BIST_from_logic_Y, in, Y_WIDTH: response.
- busy, out, 1: run in progress.
- done, out, 1: run finished (sticky).
- pass, out, 1: signature == golden; valid only while done=1.
- signature, out, SIG_WIDTH: current MISR contents.
- pat_cnt, out, 16: patterns captured this run.

## Operation
- **States:** IDLE, RST, APPLY, CAPTURE, DONE.
- **IDLE:** all strobes low.
  - On a start rising edge (start=1 now, 0 the previous cycle): LFSR←seed, MISR←0, pat_cnt←0, rst_cnt←0, done←0, pass←0; go to RST.
- **RST:**
  - BIST_to_logic_res=1, and rst_cnt increments.
  - When rst_cnt==RST_CYCLES-1, go to APPLY.
- **APPLY:** BIST_to_logic_clk=1 for this one cycle; go to CAPTURE.
- **CAPTURE:**
  - MISR←{MISR[SIG_WIDTH-2:0], ^(MISR & MISR_POLY)} XOR zero-extended Y.
  - LFSR←{LFSR[X_WIDTH-2:0], ^(LFSR & LFSR_POLY)}.
  - pat_cnt increments.
  - If pat_cnt (before the increment) == PAT_COUNT-1, go to DONE; otherwise go to APPLY.
- **DONE:** done=1 and pass=(MISR==golden) are registered on entry.
  - Both hold until the next start rising edge, which restarts exactly as from IDLE.
- **X output:** BIST_to_logic_X = LFSR in every state; it is stable across APPLY and CAPTURE.
- **busy:** 1 in RST, APPLY and CAPTURE only.
- **Start while busy:** ignored; no restart and no counter disturbance.
- **Abort:** abort=1 in any busy state returns to IDLE the next cycle.
  - done stays 0.
  - signature and pat_cnt freeze at their last values.
  - Abort takes precedence over a simultaneous completion.
- **No default feedback:** with MISR=0 and Y=0 the MISR stays 0.
- **pat_cnt limit:** pat_cnt is 16 bits and never exceeds PAT_COUNT.

## Timing
- **Reset:** BIST_res_n=0 asynchronously forces the following, mid-run included:
  - state=IDLE;
  - X=LFSR_SEED (or 1 if the seed is 0), MISR=0, signature=0, pat_cnt=0;
  - busy=0, done=0, pass=0, clk=0, res=0.
- **Start sensing:** a start edge sampled at edge k gives busy=1 and res=1 from edge k+1.
- **Run length:** RST_CYCLES + 2·PAT_COUNT cycles from the first RST cycle to the DONE entry.
- **done/pass:** both are asserted in the cycle after the final CAPTURE.
- **Y sampling:** Y is sampled at the end of CAPTURE, one cycle after the clk strobe, so the logic has a full cycle to respond.
- **Outputs:** all outputs are registered; none is combinational from an input.

## Test plan
- **Reset mid-run:** assert BIST_res_n=0 during APPLY of pattern 5 → all outputs return to their reset values immediately; release, then start → a full clean run follows.
- **LFSR sequence:** defaults, Y tied to 0 → X at successive APPLY cycles reads 0001, 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, 1111, 1110, 1100, 1000.
  - done rises 2+30 cycles after the first RST cycle.
  - signature=0; with golden=0, pass=1.
- **Loopback signature:** Y=X, PAT_COUNT=15 → signature matches a bench reference model.
  - With golden=model value: pass=1.
  - With golden=model^1: pass=0 and done=1.
- **Strobe shape:** res is high for exactly RST_CYCLES=2 cycles; clk is high for exactly 1 cycle per pattern, 15 pulses total, never overlapping res.
- **Start and abort:**
  - A start pulse at pattern 3 → ignored.
  - abort at pattern 7, coinciding with nothing → IDLE next cycle, done=0, pat_cnt=7.
  - abort in the final CAPTURE → done stays 0.
- **Restart:** a new start while done=1 → done and pass clear the next cycle, and a second identical run reproduces the same signature.

Source files
------------

// File: rtl/bist_engine_param_if.sv
// BIST engine bus: TAP-side control/results plus
// the pattern/strobe/response path to the logic.
interface bist_engine_param_if #(
  parameter int X_WIDTH   = 4,
  parameter int Y_WIDTH   = 4,
  parameter int SIG_WIDTH = 16
);
  logic                 start;
  logic                 abort;
  logic [SIG_WIDTH-1:0] golden;
  logic [X_WIDTH-1:0]   BIST_to_logic_X;
  logic                 BIST_to_logic_clk;
  logic                 BIST_to_logic_res;
  logic [Y_WIDTH-1:0]   BIST_from_logic_Y;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [SIG_WIDTH-1:0] signature;
  logic [15:0]          pat_cnt;

  modport master (
    input  start,
    input  abort,
    input  golden,
    input  BIST_from_logic_Y,
    output BIST_to_logic_X,
    output BIST_to_logic_clk,
    output BIST_to_logic_res,
    output busy,
    output done,
    output pass,
    output signature,
    output pat_cnt
  );

  modport slave (
    output start,
    output abort,
    output golden,
    output BIST_from_logic_Y,
    input  BIST_to_logic_X,
    input  BIST_to_logic_clk,
    input  BIST_to_logic_res,
    input  busy,
    input  done,
    input  pass,
    input  signature,
    input  pat_cnt
  );
endinterface

// File: rtl/bist_engine_param.sv
// Parametrised BIST engine: LFSR patterns out,
// MISR compaction of responses, golden compare.
module bist_engine_param #(
  parameter int X_WIDTH    = 4,
  parameter int Y_WIDTH    = 4,
  parameter int SIG_WIDTH  = 16,
  parameter int PAT_COUNT  = 15,
  parameter int RST_CYCLES = 2,
  parameter logic [X_WIDTH-1:0]   LFSR_POLY = 4'b1100,
  parameter logic [X_WIDTH-1:0]   LFSR_SEED = 4'b0001,
  parameter logic [SIG_WIDTH-1:0] MISR_POLY = 16'h8016
) (
  input logic clk_50MHz,
  input logic BIST_res_n,
  bist_engine_param_if.master bus
);

  localparam int RW =
    (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0] RST_LAST =
    RW'(RST_CYCLES - 1);
  localparam logic [15:0] PAT_LAST =
    16'(PAT_COUNT - 1);
  localparam logic [X_WIDTH-1:0] SEED =
    (LFSR_SEED == '0) ? X_WIDTH'(1) : LFSR_SEED;

  typedef enum logic [2:0] {
    IDLE, RST, APPLY, CAPTURE, DONE
  } state_t;

  state_t               state;
  logic                 start_q;
  logic [RW-1:0]        rst_cnt;
  logic [X_WIDTH-1:0]   lfsr;
  logic [SIG_WIDTH-1:0] misr;
  logic [15:0]          pcnt;
  logic                 busy_r;
  logic                 done_r;
  logic                 pass_r;
  logic                 clk_r;
  logic                 res_r;

  logic                 start_rise;
  logic                 last_pat;
  logic [X_WIDTH-1:0]   lfsr_nxt;
  logic [SIG_WIDTH-1:0] misr_nxt;

  // Next LFSR/MISR values and run-control decodes
  always_comb begin
    start_rise = bus.start & ~start_q;
    last_pat   = (pcnt == PAT_LAST);
    lfsr_nxt   = X_WIDTH'({lfsr, ^(lfsr & LFSR_POLY)});
    misr_nxt   = SIG_WIDTH'({misr, ^(misr & MISR_POLY)})
               ^ SIG_WIDTH'(bus.BIST_from_logic_Y);
  end

  // Run sequencer with registered strobes and status
  always_ff @(posedge clk_50MHz or negedge BIST_res_n) begin
    if (!BIST_res_n) begin
      state   <= IDLE;
      start_q <= 1'b0;
      rst_cnt <= '0;
      lfsr    <= SEED;
      misr    <= '0;
      pcnt    <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
      clk_r   <= 1'b0;
      res_r   <= 1'b0;
    end else begin
      start_q <= bus.start;
      unique case (state)
        IDLE, DONE: begin
          if (start_rise) begin
            lfsr    <= SEED;
            misr    <= '0;
            pcnt    <= '0;
            rst_cnt <= '0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
            busy_r  <= 1'b1;
            res_r   <= 1'b1;
            state   <= RST;
          end
        end
        RST: begin
          if (bus.abort) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            res_r  <= 1'b0;
            clk_r  <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
            if (rst_cnt == RST_LAST) begin
              res_r <= 1'b0;
              clk_r <= 1'b1;
              state <= APPLY;
            end
          end
        end
        APPLY: begin
          if (bus.abort) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            res_r  <= 1'b0;
            clk_r  <= 1'b0;
          end else begin
            clk_r <= 1'b0;
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (bus.abort) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            res_r  <= 1'b0;
            clk_r  <= 1'b0;
          end else begin
            misr <= misr_nxt;
            lfsr <= lfsr_nxt;
            pcnt <= pcnt + 16'd1;
            if (last_pat) begin
              state  <= DONE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
              pass_r <= (misr_nxt == bus.golden);
            end else begin
              clk_r <= 1'b1;
              state <= APPLY;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          res_r  <= 1'b0;
          clk_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.BIST_to_logic_X   = lfsr;
  assign bus.BIST_to_logic_clk = clk_r;
  assign bus.BIST_to_logic_res = res_r;
  assign bus.busy              = busy_r;
  assign bus.done              = done_r;
  assign bus.pass              = pass_r;
  assign bus.signature         = misr;
  assign bus.pat_cnt           = pcnt;

endmodule

// File: tb/tb_bist_engine_param.sv
// Bench for bist_engine_param: table runs, random
// responses vs reference model, abort/reset cases.
module tb_bist_engine_param;

  localparam int XW   = 4;
  localparam int YW   = 4;
  localparam int SW   = 16;
  localparam int PAT  = 15;
  localparam int RSTC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  bist_engine_param_if #(
    .X_WIDTH(XW), .Y_WIDTH(YW), .SIG_WIDTH(SW)
  ) bus ();

  bist_engine_param #(
    .X_WIDTH(XW), .Y_WIDTH(YW), .SIG_WIDTH(SW),
    .PAT_COUNT(PAT), .RST_CYCLES(RSTC),
    .LFSR_POLY(4'b1100), .LFSR_SEED(4'b0001),
    .MISR_POLY(16'h8016)
  ) dut (
    .clk_50MHz (clk),
    .BIST_res_n(rst_n),
    .bus       (bus)
  );

  int total = 0;
  int bad = 0;
  int ymode = 0;
  logic [3:0] lut [16];
  logic [3:0] mx [PAT];
  logic [3:0] xs [PAT];
  int busy_n, res_n, clk_n, ovl;
  bit to;
  logic first_done, first_pass;

  // Logic-under-test stand-in: Y is a function of X
  assign bus.BIST_from_logic_Y =
    (ymode == 0) ? 4'h0 :
    (ymode == 1) ? bus.BIST_to_logic_X :
    lut[bus.BIST_to_logic_X];

  task automatic check(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  function automatic int ymap(int x);
    if (ymode == 0) return 0;
    if (ymode == 1) return x;
    return int'(lut[x]);
  endfunction

  // Signature after n patterns, arithmetic form
  function automatic int model(int n);
    int l, m, par, fb;
    l = 1;
    m = 0;
    for (int i = 0; i < n; i++) begin
      mx[i] = 4'(l);
      par = $countones(m & 32'h8016) % 2;
      m = (((m * 2) % 65536) + par) ^ ymap(l);
      fb = $countones(l & 32'hC) % 2;
      l = ((l * 2) % 16) + fb;
    end
    return m;
  endfunction

  task automatic chk_reset(string tg);
    check({tg, "_x"}, int'(bus.BIST_to_logic_X), 1);
    check({tg, "_sig"}, int'(bus.signature), 0);
    check({tg, "_pat"}, int'(bus.pat_cnt), 0);
    check({tg, "_busy"}, int'(bus.busy), 0);
    check({tg, "_done"}, int'(bus.done), 0);
    check({tg, "_pass"}, int'(bus.pass), 0);
    check({tg, "_clk"},
          int'(bus.BIST_to_logic_clk), 0);
    check({tg, "_res"},
          int'(bus.BIST_to_logic_res), 0);
  endtask

  // ev: 0 none, 1 start pulse, 2 abort at APPLY,
  // 3 abort in final CAPTURE, 4 reset at APPLY
  task automatic run(int ev, int ev_pat);
    int napply;
    bit fired;
    napply = 0;
    fired = 0;
    busy_n = 0;
    res_n = 0;
    clk_n = 0;
    ovl = 0;
    to = 1;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 2000; c++) begin
      bus.start = 1'b0;
      bus.abort = 1'b0;
      if (c == 0) begin
        first_done = bus.done;
        first_pass = bus.pass;
      end
      if (!bus.busy) begin
        to = 0;
        break;
      end
      busy_n++;
      if (bus.BIST_to_logic_res) res_n++;
      if (bus.BIST_to_logic_res &&
          bus.BIST_to_logic_clk) ovl++;
      if (bus.BIST_to_logic_clk) begin
        clk_n++;
        if (napply < PAT)
          xs[napply] = bus.BIST_to_logic_X;
        if (!fired && napply == ev_pat) begin
          if (ev == 1) begin
            bus.start = 1'b1;
            fired = 1;
          end
          if (ev == 2) begin
            bus.abort = 1'b1;
            fired = 1;
          end
          if (ev == 4) begin
            rst_n = 1'b0;
            #1;
            chk_reset("mid");
            @(negedge clk);
            rst_n = 1'b1;
            to = 0;
            break;
          end
        end
        napply++;
      end else if (!bus.BIST_to_logic_res &&
                   ev == 3 && !fired &&
                   napply == PAT) begin
        bus.abort = 1'b1;
        fired = 1;
      end
      @(negedge clk);
    end
    if (to) begin
      bad++;
      total++;
      $display("FAIL run_timeout: got busy want idle");
    end
  endtask

  task automatic full_checks(string tg, int m,
                             bit ep, bit lfsr_tbl);
    logic [3:0] lexp [PAT];
    lexp = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3,
             4'h6, 4'hD, 4'hA, 4'h5, 4'hB,
             4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    check({tg, "_sig"}, int'(bus.signature), m);
    check({tg, "_done"}, int'(bus.done), 1);
    check({tg, "_pass"}, int'(bus.pass), int'(ep));
    check({tg, "_pat"}, int'(bus.pat_cnt), PAT);
    check({tg, "_len"}, busy_n, RSTC + 2 * PAT);
    check({tg, "_res_n"}, res_n, RSTC);
    check({tg, "_clk_n"}, clk_n, PAT);
    check({tg, "_ovl"}, ovl, 0);
    for (int i = 0; i < PAT; i++) begin
      if (lfsr_tbl)
        check($sformatf("%s_x%0d", tg, i),
              int'(xs[i]), int'(lexp[i]));
      else
        check($sformatf("%s_x%0d", tg, i),
              int'(xs[i]), int'(mx[i]));
    end
  endtask

  typedef struct {
    int          mode;
    logic [15:0] gx;
    bit          exp_pass;
  } vec_t;

  initial begin
    vec_t tbl [5];
    int m, m2;
    logic [15:0] gx;

    tbl[0] = '{mode: 0, gx: 16'h0000, exp_pass: 1};
    tbl[1] = '{mode: 1, gx: 16'h0000, exp_pass: 1};
    tbl[2] = '{mode: 1, gx: 16'h0001, exp_pass: 0};
    tbl[3] = '{mode: 2, gx: 16'h0000, exp_pass: 1};
    tbl[4] = '{mode: 2, gx: 16'h8000, exp_pass: 0};

    for (int i = 0; i < 16; i++)
      lut[i] = 4'($urandom);

    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.golden = '0;
    repeat (3) @(negedge clk);
    chk_reset("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      ymode = tbl[v].mode;
      m = model(PAT);
      if (v == 0) check("lfsr_sig_zero", m, 0);
      bus.golden = 16'(m) ^ tbl[v].gx;
      run(0, 0);
      full_checks($sformatf("tbl%0d", v), m,
                  tbl[v].exp_pass, v == 0);
    end

    m = model(PAT);
    run(0, 0);
    check("restart_done_clr", int'(first_done), 0);
    check("restart_pass_clr", int'(first_pass), 0);
    full_checks("restart", m, 0, 0);

    for (int r = 0; r < 4; r++) begin
      ymode = 2;
      for (int i = 0; i < 16; i++)
        lut[i] = 4'($urandom);
      m = model(PAT);
      gx = ($urandom_range(0, 1) == 0) ? 16'h0 :
           16'(1 << $urandom_range(0, 15));
      bus.golden = 16'(m) ^ gx;
      run(0, 0);
      full_checks($sformatf("rnd%0d", r), m,
                  gx == 16'h0, 0);
    end

    ymode = 1;
    m = model(PAT);
    bus.golden = 16'(m);
    run(1, 3);
    full_checks("start_busy", m, 1, 0);

    m = model(7);
    run(2, 7);
    check("ab7_len", busy_n, RSTC + 2 * 7 + 1);
    check("ab7_done", int'(bus.done), 0);
    check("ab7_busy", int'(bus.busy), 0);
    check("ab7_pat", int'(bus.pat_cnt), 7);
    check("ab7_sig", int'(bus.signature), m);
    repeat (3) @(negedge clk);
    check("ab7_pat_hold", int'(bus.pat_cnt), 7);
    check("ab7_sig_hold", int'(bus.signature), m);
    check("ab7_clk", int'(bus.BIST_to_logic_clk), 0);

    m = model(PAT - 1);
    run(3, 0);
    check("abf_len", busy_n, RSTC + 2 * PAT);
    check("abf_done", int'(bus.done), 0);
    check("abf_pass", int'(bus.pass), 0);
    check("abf_pat", int'(bus.pat_cnt), PAT - 1);
    check("abf_sig", int'(bus.signature), m);

    run(4, 5);
    #1;
    chk_reset("post");
    m2 = model(PAT);
    bus.golden = 16'(m2);
    run(0, 0);
    full_checks("clean", m2, 1, 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
